food_map_reader: RTL and testbench
==================================

// Module: food_map_reader
// PURPOSE
//  Read side of the food_map BRAM, whose write side clears the pellet bit under pacman.
//  Per display line, fetches one 80-bit food row into a line buffer during hblank.
//  Emits a pixel-aligned pellet flag for the renderer.
//  Counts remaining pellets per frame and raises level_clear.
// PARAMETERS
//  MAP_W      80  food row width in bits (matrix columns)
//  MAP_H      45  food rows in use (BRAM depth 64, addr 6 bits)
//  TILE_SHIFT 4   log2 tile size in pixels (16x16 tiles)
//  RD_LAT     2   BRAM read latency, fm_en to valid fm_dout, cycles
//  PEL_LO     6   first tile-local pixel (x and y) of pellet square
//  PEL_HI     9   last tile-local pixel of pellet square
// PORTS
//  clk           in   1   system clock; single clock domain
//  rst           in   1   synchronous reset, active-high
//  pix_x         in   11  display x of current pixel
//  pix_y         in   10  display y of current pixel
//  pix_valid     in   1   active-video pixel this cycle
//  line_start    in   1   1-cycle pulse at hblank start
//  line_y        in   10  y of the upcoming line, sampled with line_start
//  frame_start   in   1   1-cycle pulse at vblank start
//  fm_en         out  1   BRAM read enable
//  fm_addr       out  6   BRAM row address
//  fm_dout       in   80  BRAM read data
//  food_pix      out  1   pellet pixel, 2 cycles after pix_x/pix_y/pix_valid
//  food_pix_vld  out  1   pix_valid delayed 2 cycles
//  pellets_left  out  13  pellet count of last complete frame
//  count_ok      out  1   pellets_left is from a fully counted frame
//  level_clear   out  1   count_ok && pellets_left==0; level until next latch
// BEHAVIOUR
//  Reset
//   All outputs 0. Row buffer 0, accumulator 0, FSM IDLE.
//  FSM IDLE -> FETCH -> WAIT -> LOAD -> COUNT -> IDLE
//   IDLE:  on line_start, r = line_y>>TILE_SHIFT.
//          r>=MAP_H: clear buffer, stay IDLE.
//          Else go to FETCH.
//   FETCH: fm_en=1, fm_addr=r for exactly 1 cycle.
//   WAIT:  RD_LAT-1 cycles.
//   LOAD:  buffer <= fm_dout[MAP_W-1:0].
//          Always refetch, even for the same row, so eaten pellets vanish on the next line.
//   COUNT: entered only if line_y[TILE_SHIFT-1:0]==0, i.e. the first line of a tile row;
//          otherwise return to IDLE.
//          Serial popcount, 8 bits/cycle, ceil(MAP_W/8)=10 cycles.
//          Sum added to 13-bit accumulator. Total worst case ~14 cycles, well inside hblank.
//   line_start in any non-IDLE state aborts: restart at FETCH with the new row.
//          Aborted partial count is discarded and marks the frame dirty.
//  Pixel path, 2 stages
//   S1: col = pix_x>>TILE_SHIFT.
//       win = tile-local x and y both within [PEL_LO,PEL_HI].
//   S2: food_pix = pix_valid_d && win_d && col_d<MAP_W && buffer[col_d].
//       col>=MAP_W gives 0, no out-of-range index.
//  Frame latch
//   On frame_start: pellets_left <= acc; count_ok <= !dirty && rows_counted==MAP_H.
//   level_clear <= that count_ok && acc==0.
//   Then acc, rows_counted and dirty are cleared.
//   frame_start during COUNT: the in-flight row goes to the new frame's accumulator
//   (counted after the latch).
//   frame_start and line_start in the same cycle: latch first, fetch starts normally.
//  Arithmetic
//   Unsigned. acc saturates at 8191, which is unreachable with MAP_W*MAP_H=3600.
// STRUCTURE
//  Shared package food_map_pkg: MAP_W, MAP_H, TILE_SHIFT, FM_AW=6, FM_DW=80,
//  FSM state encoding, PEL_LO/PEL_HI defaults.
//  Sub-module food_row_popcount: start/busy/done handshake, 80-bit in,
//  8 bits/cycle, 7-bit count out.
//  Top holds the FSM, row buffer, pixel pipeline and frame latch.
// TESTING
//  1. BRAM model RD_LAT=2, row 3 = all ones; line_start line_y=48, then pixels
//     x=0..1279 -> fm_addr=3 one cycle; food_pix=1 exactly where x%16 in 6..9,
//     y=48 is tile-local 0 so outside window -> all 0; at line_y=54 -> pattern
//     present, 2-cycle latency.
//  2. Row 0 bit 5 only, 45 tile rows scanned, frame_start -> pellets_left=1,
//     count_ok=1, level_clear=0; clear bit, next frame -> pellets_left=0,
//     level_clear=1.
//  3. line_start again 5 cycles after first -> first fetch aborted, new row loaded,
//     frame count_ok=0 at next frame_start.
//  4. line_y=720 (row 45 >= MAP_H) -> no fm_en, food_pix=0 whole line.
//  5. frame_start and line_start same cycle -> latch of old acc, then row fetched
//     and counted into new frame.
//  6. rst asserted mid-COUNT -> next cycle all outputs 0, FSM IDLE, fm_en=0.

Source files
------------

// File: rtl/food_map_pkg.sv
`default_nettype none
// ============================================================================
// Module   : food_map_pkg
// Purpose  : Shared geometry, state encoding and helpers for the food map reader.
// Revision : 1.0
// ============================================================================
package food_map_pkg;

    localparam int MAP_W      = 80;
    localparam int MAP_H      = 45;
    localparam int TILE_SHIFT = 4;
    localparam int RD_LAT     = 2;
    localparam int FM_AW      = 6;
    localparam int FM_DW      = 80;
    localparam int PEL_LO_DEF = 6;
    localparam int PEL_HI_DEF = 9;
    localparam int CHUNK_W    = 8;
    localparam int N_CHUNK    = (MAP_W + CHUNK_W - 1) / CHUNK_W;
    localparam int ROW_CNT_W  = 7;
    localparam int ACC_W      = 13;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_LOAD  = 3'd3,
        ST_COUNT = 3'd4
    } fm_state_e;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] s;
        s = '0;
        for (int i = 0; i < 8; i++) begin
            s = s + {3'b000, v[i]};
        end
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/food_row_popcount.sv
`default_nettype none
// ============================================================================
// Module   : food_row_popcount
// Purpose  : Serial popcount of one food row, CHUNK_W bits per cycle.
// Revision : 1.0
// ============================================================================
module food_row_popcount
    import food_map_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 start,
    input  logic [MAP_W-1:0]     row,
    output logic                 busy,
    output logic                 done,
    output logic [ROW_CNT_W-1:0] count
);

    localparam int                 c_IDX_W = $clog2(N_CHUNK);
    localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(N_CHUNK - 1);

    logic [MAP_W-1:0]     r_shreg_q, w_shreg_d;
    logic [c_IDX_W-1:0]   r_idx_q,   w_idx_d;
    logic [ROW_CNT_W-1:0] r_sum_q,   w_sum_d;
    logic                 r_busy_q,  w_busy_d;
    logic                 r_done_q,  w_done_d;
    logic [ROW_CNT_W-1:0] w_chunk_sum;

    always_comb begin
        w_chunk_sum = r_sum_q + ROW_CNT_W'(popcount8(r_shreg_q[CHUNK_W-1:0]));
        w_shreg_d   = r_shreg_q;
        w_idx_d     = r_idx_q;
        w_sum_d     = r_sum_q;
        w_busy_d    = r_busy_q;
        w_done_d    = 1'b0;
        if (clr) begin
            w_busy_d = 1'b0;
            w_idx_d  = '0;
            w_sum_d  = '0;
        end else if (start) begin
            w_shreg_d = row;
            w_idx_d   = '0;
            w_sum_d   = '0;
            w_busy_d  = 1'b1;
        end else if (r_busy_q) begin
            w_shreg_d = r_shreg_q >> CHUNK_W;
            w_sum_d   = w_chunk_sum;
            w_idx_d   = r_idx_q + c_IDX_W'(1);
            if (r_idx_q == c_LAST) begin
                w_busy_d = 1'b0;
                w_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg_q <= '0;
            r_idx_q   <= '0;
            r_sum_q   <= '0;
            r_busy_q  <= 1'b0;
            r_done_q  <= 1'b0;
        end else begin
            r_shreg_q <= w_shreg_d;
            r_idx_q   <= w_idx_d;
            r_sum_q   <= w_sum_d;
            r_busy_q  <= w_busy_d;
            r_done_q  <= w_done_d;
        end
    end

    assign busy  = r_busy_q;
    assign done  = r_done_q;
    assign count = r_sum_q;

endmodule
`default_nettype wire

// File: rtl/food_map_reader.sv
`default_nettype none
// ============================================================================
// Module   : food_map_reader
// Purpose  : Per-line food row fetch, pixel pellet flag and per-frame pellet count.
// Revision : 1.0
// ============================================================================
module food_map_reader
    import food_map_pkg::*;
#(
    parameter int PEL_LO = PEL_LO_DEF,
    parameter int PEL_HI = PEL_HI_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [10:0]      pix_x,
    input  logic [9:0]       pix_y,
    input  logic             pix_valid,
    input  logic             line_start,
    input  logic [9:0]       line_y,
    input  logic             frame_start,
    output logic             fm_en,
    output logic [FM_AW-1:0] fm_addr,
    input  logic [FM_DW-1:0] fm_dout,
    output logic             food_pix,
    output logic             food_pix_vld,
    output logic [ACC_W-1:0] pellets_left,
    output logic             count_ok,
    output logic             level_clear
);

    localparam int                    c_COL_W     = 11 - TILE_SHIFT;
    localparam int                    c_SUM_W     = ACC_W + 1;
    localparam logic [c_COL_W-1:0]    c_MAP_W_COL = c_COL_W'(MAP_W);
    localparam logic [FM_AW-1:0]      c_MAP_H_ROW = FM_AW'(MAP_H);
    localparam logic [TILE_SHIFT-1:0] c_PEL_LO    = TILE_SHIFT'(PEL_LO);
    localparam logic [TILE_SHIFT-1:0] c_PEL_HI    = TILE_SHIFT'(PEL_HI);
    localparam logic [3:0]            c_WAIT_INIT = 4'(RD_LAT - 2);
    localparam logic [FM_AW-1:0]      c_ROWS_MAX  = '1;
    localparam logic [ACC_W-1:0]      c_ACC_MAX   = '1;

    fm_state_e            r_state_q, w_state_d;
    logic [FM_AW-1:0]     r_row_q, w_row_d;
    logic                 r_cnt_line_q, w_cnt_line_d;
    logic [3:0]           r_wait_q, w_wait_d;
    logic [MAP_W-1:0]     r_buf_q, w_buf_d;
    logic                 r_fm_en_q, w_fm_en_d;
    logic [FM_AW-1:0]     r_fm_addr_q, w_fm_addr_d;
    logic [ACC_W-1:0]     r_acc_q, w_acc_d;
    logic [FM_AW-1:0]     r_rows_q, w_rows_d;
    logic                 r_dirty_q, w_dirty_d;
    logic [ACC_W-1:0]     r_pellets_q, w_pellets_d;
    logic                 r_count_ok_q, w_count_ok_d;
    logic                 r_level_clear_q, w_level_clear_d;
    logic [c_COL_W-1:0]   r_col_q, w_col_d;
    logic                 r_win_q, w_win_d;
    logic                 r_vld1_q, w_vld1_d;
    logic                 r_food_pix_q, w_food_pix_d;
    logic                 r_vld2_q, w_vld2_d;

    logic [FM_AW-1:0]     w_line_row;
    logic                 w_line_on_map;
    logic [ACC_W-1:0]     w_acc_base;
    logic [FM_AW-1:0]     w_rows_base;
    logic                 w_dirty_base;
    logic [c_SUM_W-1:0]   w_acc_sum;
    logic                 w_pc_start, w_pc_clr, w_pc_busy, w_pc_done;
    logic [ROW_CNT_W-1:0] w_pc_count;
    logic [(2**c_COL_W)-1:0] w_buf_ext;
    logic                 w_unused;

    assign w_unused = ^pix_y[9:TILE_SHIFT];

    food_row_popcount u_popcount (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_pc_clr),
        .start (w_pc_start),
        .row   (fm_dout),
        .busy  (w_pc_busy),
        .done  (w_pc_done),
        .count (w_pc_count)
    );

    always_comb begin
        w_state_d       = r_state_q;
        w_row_d         = r_row_q;
        w_cnt_line_d    = r_cnt_line_q;
        w_wait_d        = r_wait_q;
        w_buf_d         = r_buf_q;
        w_pellets_d     = r_pellets_q;
        w_count_ok_d    = r_count_ok_q;
        w_level_clear_d = r_level_clear_q;
        w_pc_start      = 1'b0;
        w_pc_clr        = 1'b0;
        w_line_row      = line_y[9:TILE_SHIFT];
        w_line_on_map   = (w_line_row < c_MAP_H_ROW);

        // Latch happens before any count completing this cycle, so that count
        // lands in the new frame.
        w_acc_base   = r_acc_q;
        w_rows_base  = r_rows_q;
        w_dirty_base = r_dirty_q;
        if (frame_start) begin
            w_pellets_d     = r_acc_q;
            w_count_ok_d    = !r_dirty_q && (r_rows_q == c_MAP_H_ROW);
            w_level_clear_d = w_count_ok_d && (r_acc_q == '0);
            w_acc_base      = '0;
            w_rows_base     = '0;
            w_dirty_base    = 1'b0;
        end
        w_acc_d   = w_acc_base;
        w_rows_d  = w_rows_base;
        w_dirty_d = w_dirty_base;
        w_acc_sum = {1'b0, w_acc_base} + c_SUM_W'(w_pc_count);

        case (r_state_q)
            ST_IDLE: begin
                if (line_start) begin
                    w_row_d      = w_line_row;
                    w_cnt_line_d = (line_y[TILE_SHIFT-1:0] == '0);
                    if (w_line_on_map) begin
                        w_state_d = ST_FETCH;
                    end else begin
                        w_buf_d = '0;
                    end
                end
            end
            ST_FETCH: begin
                w_state_d = ST_WAIT;
                w_wait_d  = c_WAIT_INIT;
            end
            ST_WAIT: begin
                if (r_wait_q == '0) begin
                    w_state_d = ST_LOAD;
                end else begin
                    w_wait_d = r_wait_q - 4'd1;
                end
            end
            ST_LOAD: begin
                w_buf_d = fm_dout[MAP_W-1:0];
                if (r_cnt_line_q) begin
                    w_pc_start = 1'b1;
                    w_state_d  = ST_COUNT;
                end else begin
                    w_state_d = ST_IDLE;
                end
            end
            ST_COUNT: begin
                if (w_pc_done) begin
                    w_acc_d   = w_acc_sum[ACC_W] ? c_ACC_MAX : w_acc_sum[ACC_W-1:0];
                    w_rows_d  = (w_rows_base == c_ROWS_MAX) ? w_rows_base
                                                            : w_rows_base + FM_AW'(1);
                    w_state_d = ST_IDLE;
                end else if (!w_pc_busy) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        // A new line preempts whatever is in flight; a lost row count taints the frame.
        if (line_start && (r_state_q != ST_IDLE)) begin
            w_pc_clr     = 1'b1;
            w_pc_start   = 1'b0;
            if (r_cnt_line_q && !((r_state_q == ST_COUNT) && w_pc_done)) begin
                w_dirty_d = 1'b1;
            end
            w_row_d      = w_line_row;
            w_cnt_line_d = (line_y[TILE_SHIFT-1:0] == '0);
            if (w_line_on_map) begin
                w_state_d = ST_FETCH;
            end else begin
                w_state_d = ST_IDLE;
                w_buf_d   = '0;
            end
        end

        w_fm_en_d   = (w_state_d == ST_FETCH);
        w_fm_addr_d = (w_state_d == ST_FETCH) ? w_row_d : r_fm_addr_q;

        w_col_d      = pix_x[10:TILE_SHIFT];
        w_win_d      = (pix_x[TILE_SHIFT-1:0] >= c_PEL_LO) && (pix_x[TILE_SHIFT-1:0] <= c_PEL_HI) &&
                       (pix_y[TILE_SHIFT-1:0] >= c_PEL_LO) && (pix_y[TILE_SHIFT-1:0] <= c_PEL_HI);
        w_vld1_d     = pix_valid;
        w_buf_ext    = {{((2**c_COL_W) - MAP_W){1'b0}}, r_buf_q};
        w_food_pix_d = r_vld1_q && r_win_q && (r_col_q < c_MAP_W_COL) && w_buf_ext[r_col_q];
        w_vld2_d     = r_vld1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q       <= ST_IDLE;
            r_row_q         <= '0;
            r_cnt_line_q    <= 1'b0;
            r_wait_q        <= '0;
            r_buf_q         <= '0;
            r_fm_en_q       <= 1'b0;
            r_fm_addr_q     <= '0;
            r_acc_q         <= '0;
            r_rows_q        <= '0;
            r_dirty_q       <= 1'b0;
            r_pellets_q     <= '0;
            r_count_ok_q    <= 1'b0;
            r_level_clear_q <= 1'b0;
            r_col_q         <= '0;
            r_win_q         <= 1'b0;
            r_vld1_q        <= 1'b0;
            r_food_pix_q    <= 1'b0;
            r_vld2_q        <= 1'b0;
        end else begin
            r_state_q       <= w_state_d;
            r_row_q         <= w_row_d;
            r_cnt_line_q    <= w_cnt_line_d;
            r_wait_q        <= w_wait_d;
            r_buf_q         <= w_buf_d;
            r_fm_en_q       <= w_fm_en_d;
            r_fm_addr_q     <= w_fm_addr_d;
            r_acc_q         <= w_acc_d;
            r_rows_q        <= w_rows_d;
            r_dirty_q       <= w_dirty_d;
            r_pellets_q     <= w_pellets_d;
            r_count_ok_q    <= w_count_ok_d;
            r_level_clear_q <= w_level_clear_d;
            r_col_q         <= w_col_d;
            r_win_q         <= w_win_d;
            r_vld1_q        <= w_vld1_d;
            r_food_pix_q    <= w_food_pix_d;
            r_vld2_q        <= w_vld2_d;
        end
    end

    assign fm_en        = r_fm_en_q;
    assign fm_addr      = r_fm_addr_q;
    assign food_pix     = r_food_pix_q;
    assign food_pix_vld = r_vld2_q;
    assign pellets_left = r_pellets_q;
    assign count_ok     = r_count_ok_q;
    assign level_clear  = r_level_clear_q;

endmodule
`default_nettype wire

// File: tb/tb_food_map_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_food_map_reader
// Purpose  : Self-checking bench for food_map_reader with a 2-cycle BRAM model.
// Revision : 1.0
// ============================================================================
module tb_food_map_reader;

    logic        clk;
    logic        rst;
    logic [10:0] pix_x;
    logic [9:0]  pix_y;
    logic        pix_valid;
    logic        line_start;
    logic [9:0]  line_y;
    logic        frame_start;
    logic        fm_en;
    logic [5:0]  fm_addr;
    logic [79:0] fm_dout;
    logic        food_pix;
    logic        food_pix_vld;
    logic [12:0] pellets_left;
    logic        count_ok;
    logic        level_clear;

    logic [79:0] mem [0:63];
    logic [79:0] rd1;
    int          cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;

    typedef struct {
        int   x;
        logic exp;
        int   t;
    } sb_t;
    sb_t sb_q[$];

    food_map_reader dut (
        .clk          (clk),
        .rst          (rst),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .pix_valid    (pix_valid),
        .line_start   (line_start),
        .line_y       (line_y),
        .frame_start  (frame_start),
        .fm_en        (fm_en),
        .fm_addr      (fm_addr),
        .fm_dout      (fm_dout),
        .food_pix     (food_pix),
        .food_pix_vld (food_pix_vld),
        .pellets_left (pellets_left),
        .count_ok     (count_ok),
        .level_clear  (level_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fm_en) rd1 <= mem[fm_addr];
        fm_dout <= rd1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_pix(input int x, input int y, input logic [79:0] b);
        int col;
        logic win;
        col = x / 16;
        win = (x % 16 >= 6) && (x % 16 <= 9) && (y % 16 >= 6) && (y % 16 <= 9);
        if (!win || col >= 80) return 1'b0;
        return b[col];
    endfunction

    task automatic do_line(input int y, output int n_en, output int addr);
        line_y = 10'(y);
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        n_en = 0;
        addr = -1;
        repeat (20) begin
            if (fm_en) begin
                n_en++;
                addr = int'(fm_addr);
            end
            tick();
        end
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic scan(input int y, input int x0, input int x1, input logic [79:0] b);
        sb_t e;
        int  lat;
        for (int x = x0; x <= x1 + 3; x++) begin
            if (x <= x1) begin
                pix_x = 11'(x);
                pix_y = 10'(y);
                pix_valid = 1'b1;
                e.x = x;
                e.exp = exp_pix(x, y, b);
                e.t = cyc;
                sb_q.push_back(e);
            end else begin
                pix_valid = 1'b0;
            end
            tick();
            if (food_pix_vld) begin
                n_total++;
                if (sb_q.size() == 0) begin
                    $display("FAIL pix_extra y=%0d got vld=1 want no output", y);
                end else begin
                    e = sb_q.pop_front();
                    lat = cyc - e.t;
                    if ({food_pix, lat} !== {e.exp, 32'd2})
                        $display("FAIL pix y=%0d x=%0d got=%b lat=%0d want=%b lat=2",
                                 y, e.x, food_pix, lat, e.exp);
                    else n_pass++;
                end
            end
        end
        n_total++;
        if (sb_q.size() != 0)
            $display("FAIL pix_missing y=%0d got %0d unanswered want 0", y, sb_q.size());
        else n_pass++;
        sb_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_total++; if (fm_en !== 1'b0) $display("FAIL rst_fm_en got=%b want=0", fm_en); else n_pass++;
        n_total++; if (fm_addr !== 6'd0) $display("FAIL rst_fm_addr got=%0d want=0", fm_addr); else n_pass++;
        n_total++; if (food_pix !== 1'b0) $display("FAIL rst_food_pix got=%b want=0", food_pix); else n_pass++;
        n_total++; if (food_pix_vld !== 1'b0) $display("FAIL rst_vld got=%b want=0", food_pix_vld); else n_pass++;
        n_total++; if (pellets_left !== 13'd0) $display("FAIL rst_pellets got=%0d want=0", pellets_left); else n_pass++;
        n_total++; if ({count_ok, level_clear} !== 2'b00) $display("FAIL rst_flags got=%b want=00", {count_ok, level_clear}); else n_pass++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_row_fetch();
        int n, a;
        mem[3] = '1;
        do_line(48, n, a);
        n_total++; if ({n, a} !== {32'd1, 32'd3}) $display("FAIL fetch48 got n=%0d addr=%0d want n=1 addr=3", n, a); else n_pass++;
        scan(48, 0, 1279, mem[3]);
        do_line(54, n, a);
        n_total++; if ({n, a} !== {32'd1, 32'd3}) $display("FAIL fetch54 got n=%0d addr=%0d want n=1 addr=3", n, a); else n_pass++;
        scan(54, 0, 1279, mem[3]);
        scan(54, 1280, 1311, mem[3]);
        scan(54, 2032, 2047, mem[3]);
    endtask

    task automatic test_count();
        int n, a;
        logic [79:0] v;
        v = '0;
        v[5] = 1'b1;
        mem[3] = '0;
        mem[0] = v;
        pulse_frame();
        for (int k = 0; k < 45; k++) begin
            do_line(16 * k, n, a);
            if (k == 44) begin
                n_total++; if ({n, a} !== {32'd1, 32'd44}) $display("FAIL fetch_last got n=%0d addr=%0d want n=1 addr=44", n, a); else n_pass++;
            end
        end
        pulse_frame();
        n_total++; if ({pellets_left, count_ok, level_clear} !== {13'd1, 1'b1, 1'b0})
            $display("FAIL count_one got left=%0d ok=%b clr=%b want left=1 ok=1 clr=0", pellets_left, count_ok, level_clear); else n_pass++;
        mem[0] = '0;
        for (int k = 0; k < 45; k++) do_line(16 * k, n, a);
        pulse_frame();
        n_total++; if ({pellets_left, count_ok, level_clear} !== {13'd0, 1'b1, 1'b1})
            $display("FAIL count_zero got left=%0d ok=%b clr=%b want left=0 ok=1 clr=1", pellets_left, count_ok, level_clear); else n_pass++;
    endtask

    task automatic test_abort();
        int n, a;
        logic [79:0] v;
        v = {40{2'b10}};
        mem[1] = v;
        pulse_frame();
        line_y = 10'd0;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        repeat (4) tick();
        do_line(16, n, a);
        n_total++; if ({n, a} !== {32'd1, 32'd1}) $display("FAIL abort_refetch got n=%0d addr=%0d want n=1 addr=1", n, a); else n_pass++;
        scan(22, 0, 159, v);
        do_line(0, n, a);
        for (int k = 2; k < 45; k++) do_line(16 * k, n, a);
        pulse_frame();
        n_total++; if ({pellets_left, count_ok, level_clear} !== {13'd40, 1'b0, 1'b0})
            $display("FAIL abort_frame got left=%0d ok=%b clr=%b want left=40 ok=0 clr=0", pellets_left, count_ok, level_clear); else n_pass++;
    endtask

    task automatic test_off_map();
        int n, a;
        mem[1] = '0;
        mem[3] = '1;
        do_line(54, n, a);
        do_line(720, n, a);
        n_total++; if (n !== 0) $display("FAIL offmap_fetch got n=%0d want 0", n); else n_pass++;
        scan(726, 0, 1279, 80'd0);
    endtask

    task automatic test_frame_line_same();
        int n, a;
        pulse_frame();
        do_line(48, n, a);
        line_y = 10'd48;
        frame_start = 1'b1;
        line_start = 1'b1;
        tick();
        frame_start = 1'b0;
        line_start = 1'b0;
        n_total++; if ({pellets_left, count_ok, level_clear} !== {13'd80, 1'b0, 1'b0})
            $display("FAIL same_latch got left=%0d ok=%b clr=%b want left=80 ok=0 clr=0", pellets_left, count_ok, level_clear); else n_pass++;
        n = 0; a = -1;
        repeat (20) begin
            if (fm_en) begin n++; a = int'(fm_addr); end
            tick();
        end
        n_total++; if ({n, a} !== {32'd1, 32'd3}) $display("FAIL same_fetch got n=%0d addr=%0d want n=1 addr=3", n, a); else n_pass++;
        pulse_frame();
        n_total++; if (pellets_left !== 13'd80) $display("FAIL same_newframe got left=%0d want 80", pellets_left); else n_pass++;
        // frame_start while the row is mid-count
        line_y = 10'd48;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        repeat (5) tick();
        pulse_frame();
        n_total++; if (pellets_left !== 13'd0) $display("FAIL midcount_latch got left=%0d want 0", pellets_left); else n_pass++;
        repeat (15) tick();
        pulse_frame();
        n_total++; if (pellets_left !== 13'd80) $display("FAIL midcount_next got left=%0d want 80", pellets_left); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int n, a;
        pix_x = 11'd6;
        pix_y = 10'd54;
        pix_valid = 1'b1;
        line_y = 10'd48;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        repeat (5) tick();
        n_total++; if (food_pix !== 1'b1) $display("FAIL pre_rst_pix got=%b want=1", food_pix); else n_pass++;
        rst = 1'b1;
        tick();
        n_total++; if ({fm_en, food_pix, food_pix_vld} !== 3'b000) $display("FAIL midrst_pix got=%b want=000", {fm_en, food_pix, food_pix_vld}); else n_pass++;
        n_total++; if ({pellets_left, count_ok, level_clear} !== 15'd0)
            $display("FAIL midrst_frame got left=%0d ok=%b clr=%b want all 0", pellets_left, count_ok, level_clear); else n_pass++;
        rst = 1'b0;
        pix_valid = 1'b0;
        repeat (20) tick();
        pulse_frame();
        n_total++; if (pellets_left !== 13'd0) $display("FAIL midrst_leak got left=%0d want 0", pellets_left); else n_pass++;
        do_line(48, n, a);
        n_total++; if ({n, a} !== {32'd1, 32'd3}) $display("FAIL midrst_alive got n=%0d addr=%0d want n=1 addr=3", n, a); else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        rd1 = '0;
        fm_dout = '0;
        rst = 1'b1;
        pix_x = '0;
        pix_y = '0;
        pix_valid = 1'b0;
        line_start = 1'b0;
        line_y = '0;
        frame_start = 1'b0;
        test_reset();
        test_row_fetch();
        test_count();
        test_abort();
        test_off_map();
        test_frame_line_same();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
